// File: rtl/pipe_barrel_shifter.sv
// Pipelined log-depth barrel shifter (SLL/SRL/SRA/ROR) made of 2:1 mux columns,
// one registered column per shift-amount bit, with a valid/ready handshake.

module mux2x1 (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic y
);
    assign y = sel ? in1 : in0;
endmodule

module pipe_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    typedef logic [WIDTH-1:0] word_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic [SHW-1:0][WIDTH-1:0] src_data, sh_data, col_data, data_d, data_q;
    logic [SHW-1:0][1:0]       src_op, op_d, op_q;
    logic [SHW-1:0][SHW-1:0]   src_shamt, shamt_d, shamt_q;
    logic [SHW-1:0]            src_vld, vld_d, vld_q;
    logic                      stall;
    logic                      unused_tail;

    // Shifted-by-amt mux leg. For SRA the current MSB is the operand's original
    // sign bit, since no stage shifts by WIDTH or more.
    function automatic word_t shift_leg(input word_t d, input logic [1:0] op,
                                        input int unsigned amt);
        logic signed [WIDTH-1:0] ds;
        word_t                   r;
        ds = d;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = $unsigned(ds >>> amt);
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    assign stall     = vld_q[SHW-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_q[SHW-1];
    assign out_data  = data_q[SHW-1];

    // Each stage consumes shamt bit 0 and forwards the remaining bits downshifted.
    always_comb begin
        src_data[0]  = in_data;
        src_op[0]    = in_op;
        src_shamt[0] = in_shamt;
        src_vld[0]   = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_op[k]    = op_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_vld[k]   = vld_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            sh_data[k] = shift_leg(src_data[k], src_op[k], 1 << k);
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_col
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            mux2x1 u_mux (
                .in0 (src_data[k][b]),
                .in1 (sh_data[k][b]),
                .sel (src_shamt[k][0]),
                .y   (col_data[k][b])
            );
        end
    end

    always_comb begin
        data_d  = data_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        vld_d   = vld_q;
        if (!stall) begin
            data_d = col_data;
            op_d   = src_op;
            vld_d  = src_vld;
            for (int k = 0; k < SHW; k++) begin
                shamt_d[k] = src_shamt[k] >> 1;
            end
        end
    end

    // Stage registers: column k output lands in index k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            vld_q   <= '0;
        end else begin
            data_q  <= data_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            vld_q   <= vld_d;
        end
    end

    assign unused_tail = ^{op_q[SHW-1], shamt_q[SHW-1]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter (WIDTH=8, SHW=3): the driver pushes
// expected results, a negedge monitor pops and compares on each output transfer.

module tb_pipe_barrel_shifter;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic [1:0] in_op = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    int         pop_cyc[$];
    bit         rnd_en;

    pipe_barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s,
                                         input logic [1:0] op);
        logic [15:0] x;
        case (op)
            SLL:     x = {8'h00, d} << s;
            SRL:     x = {8'h00, d} >> s;
            SRA:     x = {{8{d[7]}}, d} >> s;
            default: x = {d, d} >> s;
        endcase
        return x[7:0];
    endfunction

    // Monitor: a transfer happens at the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got %0h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {24'h0, out_data}, {24'h0, e});
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op,
                        input logic [7:0] exp, input bit push);
        bit acc = 1'b0;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        else if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int vcount;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_shamt  = 3'($urandom);
            in_op     = 2'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", {31'h0, out_valid}, 32'd0);
            check("rst_out_data", {24'h0, out_data}, 32'h00);
            check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;

        // First operation and exact latency
        send(8'h81, 3'd1, SLL, 8'h02, 1'b1);
        @(negedge clk);
        check("lat_e0_valid", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_e1_valid", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_e2_valid", {31'h0, out_valid}, 32'd1);
        check("lat_e2_data", {24'h0, out_data}, 32'h02);
        @(posedge clk);
        #1;

        // All ops back to back
        base = pop_cyc.size();
        send(8'h80, 3'd7, SRL, 8'h01, 1'b1);
        send(8'h90, 3'd3, SRA, 8'hF2, 1'b1);
        send(8'h96, 3'd4, ROR, 8'h69, 1'b1);
        send(8'hFF, 3'd0, SLL, 8'hFF, 1'b1);
        wait_drain();
        if (pop_cyc.size() >= base + 4)
            check("back_to_back_span", pop_cyc[base+3] - pop_cyc[base], 32'd3);
        else
            check("back_to_back_count", pop_cyc.size() - base, 32'd4);

        // Backpressure
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'h01, 3'(i), SLL, 8'(8'h01 << i), 1'b1);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    out_ready = !(i >= 3 && i <= 6);
                    if (!out_ready) begin
                        @(negedge clk);
                        check("bp_in_ready", {31'h0, in_ready}, 32'd0);
                        check("bp_out_valid", {31'h0, out_valid}, 32'd1);
                        check("bp_out_data_held", {24'h0, out_data}, 32'h01);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Bubbles with random backpressure
        rnd_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [7:0] d;
                    logic [2:0] s;
                    logic [1:0] op;
                    d  = 8'($urandom);
                    s  = 3'($urandom);
                    op = 2'($urandom);
                    send(d, s, op, model(d, s, op), 1'b1);
                    @(posedge clk);
                    #1;
                end
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Mid-flight reset: results must never appear
        out_ready = 1'b0;
        send(8'h80, 3'd1, SRA, 8'hC0, 1'b0);
        send(8'h80, 3'd2, SRA, 8'hE0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'h0, out_valid}, 32'd1);
        check("pre_rst_data", {24'h0, out_data}, 32'hC0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'd0);
        check("async_rst_data", {24'h0, out_data}, 32'h00);
        check("async_rst_in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("post_rst_no_output", vcount, 32'd0);
        @(posedge clk);
        #1;

        // Exhaustive sweep
        for (int op = 0; op < 4; op++)
            for (int s = 0; s < 8; s++)
                for (int d = 0; d < 256; d++)
                    send(8'(d), 3'(s), 2'(op), model(8'(d), 3'(s), 2'(op)), 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
